ttl_gate_bank_reg: RTL

//  - Parametrised registered successor to the quad 2-input gate parts: CHANNELS gates, each WIDTH bits wide.
//  - Run-time selectable logic function (AND/OR/NAND/NOR/XOR/XNOR/PASS/INVERT).
//  - One pipeline register with a valid/ready handshake and a wrapping transfer counter.
//  - Sits between TTL-level component models and the Baby datapath wherever a clocked, function-selectable gate array is needed.
//

---
 rtl/ttl_gate_bank_reg.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ttl_gate_bank_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ttl_gate_bank_reg
//  Purpose  : Bank of CHANNELS function-selectable WIDTH-bit gates feeding a
//             single valid/ready pipeline register, with a wrapping count of
//             accepted inputs.
//  Revision : 1.0  initial release
// ============================================================================
module ttl_gate_bank_reg #(
   parameter int CHANNELS          = 4,
   parameter int WIDTH             = 1,
   parameter int PROPAGATION_DELAY = 10,
   parameter int COUNT_WIDTH       = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_mode_load,
   input  logic [2:0]                   i_mode_in,
   output logic [2:0]                   o_mode,
   input  logic [CHANNELS*WIDTH-1:0]    i_a,
   input  logic [CHANNELS*WIDTH-1:0]    i_b,
   input  logic                         i_in_valid,
   output logic                         o_in_ready,
   output logic [CHANNELS*WIDTH-1:0]    o_y,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic [COUNT_WIDTH-1:0]       o_xfer_count
);

   localparam int c_BITS = CHANNELS * WIDTH;

   localparam logic [2:0] c_MODE_AND  = 3'b000;
   localparam logic [2:0] c_MODE_OR   = 3'b001;
   localparam logic [2:0] c_MODE_NAND = 3'b010;
   localparam logic [2:0] c_MODE_NOR  = 3'b011;
   localparam logic [2:0] c_MODE_XOR  = 3'b100;
   localparam logic [2:0] c_MODE_XNOR = 3'b101;
   localparam logic [2:0] c_MODE_PASS = 3'b110;
   localparam logic [2:0] c_MODE_INV  = 3'b111;

   localparam logic [COUNT_WIDTH-1:0] c_COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // The clock-to-output delay belongs to the simulation model of the part;
   // synthesized outputs are driven directly. A negative delay is meaningless.
   generate
      if (PROPAGATION_DELAY < 0) begin : g_bad_delay
         $error("ttl_gate_bank_reg: PROPAGATION_DELAY must be non-negative");
      end
   endgenerate

   state_t                   r_state;
   state_t                   w_state_next;
   logic [2:0]               r_mode;
   logic [c_BITS-1:0]        r_y;
   logic [c_BITS-1:0]        w_result;
   logic [COUNT_WIDTH-1:0]   r_xfer_count;
   logic                     w_in_ready;
   logic                     w_accept;
   logic                     w_drain;

   // Handshake qualifiers: a full register that is being drained can accept
   // in the same cycle, giving one result per clock.
   always_comb begin
      w_in_ready = (r_state == ST_EMPTY) || i_out_ready;
      w_accept   = i_in_valid && w_in_ready;
      w_drain    = (r_state == ST_FULL) && i_out_ready;
   end

   // Selected logic function, applied bitwise across all channels at once;
   // X/Z on the operands propagates through the operators unmasked.
   always_comb begin
      w_result = '0;
      case (r_mode)
         c_MODE_AND  : w_result =   i_a & i_b;
         c_MODE_OR   : w_result =   i_a | i_b;
         c_MODE_NAND : w_result = ~(i_a & i_b);
         c_MODE_NOR  : w_result = ~(i_a | i_b);
         c_MODE_XOR  : w_result =   i_a ^ i_b;
         c_MODE_XNOR : w_result = ~(i_a ^ i_b);
         c_MODE_PASS : w_result =   i_a;
         c_MODE_INV  : w_result =  ~i_a;
         default     : w_result = '0;
      endcase
   end

   // Next-state: accept always fills, a drain without accept empties.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY : if (w_accept) w_state_next = ST_FULL;
         ST_FULL  : if (w_drain && !w_accept) w_state_next = ST_EMPTY;
         default  : w_state_next = ST_EMPTY;
      endcase
   end

   // State register; reset discards any held result.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_EMPTY;
      else       r_state <= w_state_next;
   end

   // Mode register; an accept on the loading edge still sees the old mode.
   always_ff @(posedge i_clk) begin
      if (i_rst)            r_mode <= c_MODE_AND;
      else if (i_mode_load) r_mode <= i_mode_in;
   end

   // Result register: only updated on accept, so a mode change never alters it.
   always_ff @(posedge i_clk) begin
      if (i_rst)         r_y <= '0;
      else if (w_accept) r_y <= w_result;
   end

   // Accepted-input counter, wrapping silently.
   always_ff @(posedge i_clk) begin
      if (i_rst)         r_xfer_count <= '0;
      else if (w_accept) r_xfer_count <= r_xfer_count + c_COUNT_ONE;
   end

   assign o_mode       = r_mode;
   assign o_y          = r_y;
   assign o_out_valid  = (r_state == ST_FULL);
   assign o_in_ready   = w_in_ready;
   assign o_xfer_count = r_xfer_count;

endmodule
`default_nettype wire
